// File: rtl/leve_ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// AXI burst encodings normally arrive from defs.vh; the fallback keeps the
// package self-contained when that header is not on the include path.
`ifndef AXI_BURST_WRAP
`define AXI_BURST_WRAP 2'b10
`endif

package leve_ifetch_pkg;

  localparam int LEVE_PC_W   = 64;
  localparam int LEVE_DATA_W = 32;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // One buffered instruction: word, its fetch PC and the bus error flag.
  typedef struct packed {
    logic [LEVE_DATA_W-1:0] data;
    logic [LEVE_PC_W-1:0]   pc;
    logic                   err;
  } fetch_ent_t;

endpackage

// File: rtl/leve_ifetch_fifo.sv
// Small instruction buffer. Holds at most one line of kept beats; a flush
// empties it and takes priority over a same-cycle push or pop.
module leve_ifetch_fifo
  import leve_ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  fetch_ent_t i_wdata,
  input  logic       i_pop,
  output logic       o_empty,
  output fetch_ent_t o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_ent_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push && (r_cnt != (AW+1)'(DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];

  // Storage and pointers; storage is cleared on reset so the head reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/leve_ifetch_ctrl.sv
// Instruction-fetch sequencer: one wrapping AXI read burst per fetch line,
// keeps the beats from the requested word to the end of the line, and hands
// them to decode tagged with their PC. Redirects never retract ARVALID; an
// in-flight burst is drained instead.
module leve_ifetch_ctrl
  import leve_ifetch_pkg::*;
#(
  parameter int PC_W   = LEVE_PC_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = LEVE_DATA_W,
  parameter int BEATS  = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic [PC_W-1:0]   i_pc_pc,
  input  logic              i_redirect,
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [7:0]        o_arlen,
  output logic [1:0]        o_arburst,
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rlast,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [DATA_W-1:0] o_inst_data,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic              o_inst_err
);

  localparam int OW = $clog2(BEATS);
  localparam int CW = OW + 1;

  state_e            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [ADDR_W-1:0] r_araddr;
  logic [CW-1:0]     r_keep;
  logic [CW-1:0]     r_k;
  logic              r_flush;
  logic              r_arvalid;
  logic              r_rready;

  logic              w_empty;
  logic              w_pc_ready;
  logic              w_accept;
  logic [PC_W-1:0]   w_pc_al;
  logic [OW-1:0]     w_off;
  logic              w_push;
  fetch_ent_t        w_ent;
  fetch_ent_t        w_head;

  // Reset gating keeps PC_READY low while the block is held in reset.
  assign w_pc_ready = (r_state == S_IDLE) && (w_empty || i_redirect) && i_rstn;
  assign w_accept   = i_pc_valid && w_pc_ready;
  assign w_pc_al    = i_pc_pc & ~PC_W'(3);
  assign w_off      = i_pc_pc[OW+1:2];

  // Only beats up to the end of the line are kept; a redirect drops the beat.
  assign w_push     = (r_state == S_DATA) && i_rvalid && (r_k < r_keep) && !i_redirect;
  assign w_ent.data = i_rdata;
  assign w_ent.pc   = r_pc + (PC_W'(r_k) << 2);
  assign w_ent.err  = (i_rresp != RRESP_OKAY);

  // Sequencer: request accept, address phase, data phase and drain.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_araddr  <= '0;
      r_keep    <= '0;
      r_k       <= '0;
      r_flush   <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc      <= w_pc_al;
            r_araddr  <= w_pc_al[ADDR_W-1:0];
            r_keep    <= CW'(BEATS) - CW'(w_off);
            r_k       <= '0;
            r_flush   <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (i_redirect) r_flush <= 1'b1;
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_flush   <= 1'b0;
            r_state   <= (r_flush || i_redirect) ? S_DRAIN : S_DATA;
          end
        end
        S_DATA: begin
          if (i_rvalid && (r_k != CW'(BEATS))) r_k <= r_k + CW'(1);
          if (i_rvalid && i_rlast) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end else if (i_redirect) begin
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_rvalid && i_rlast) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  leve_ifetch_fifo #(.DEPTH(BEATS)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rstn),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_wdata (w_ent),
    .i_pop   (i_inst_ready),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign o_pc_ready   = w_pc_ready;
  assign o_arvalid    = r_arvalid;
  assign o_araddr     = r_araddr;
  assign o_arlen      = 8'(BEATS - 1);
  assign o_arburst    = `AXI_BURST_WRAP;
  assign o_rready     = r_rready;
  assign o_inst_valid = !w_empty;
  assign o_inst_data  = w_head.data;
  assign o_inst_pc    = w_head.pc;
  assign o_inst_err   = w_head.err;

endmodule

// File: doc/leve_ifetch_ctrl.md
# leve_ifetch_ctrl

Instruction-fetch sequencer between the PC generator and the instruction AXI read port. It takes one fetch request per line from the PC stage and issues a 4-beat wrapping read burst. It buffers the returned beats and hands instructions to the decode stage over a valid/ready handshake, each instruction tagged with its PC. It handles pipeline redirects mid-transaction without violating AXI rules.

## Interface
- PC_W, 64, width of the PC from the PC stage
- ADDR_W, 32, AXI address width; ARADDR = PC[ADDR_W-1:0]
- DATA_W, 32, RDATA width; one instruction per beat
- BEATS, 4, beats per burst (power of two); ARLEN = BEATS-1
- CLK  in  1  clock; all logic on rising edge
- RSTn  in  1  asynchronous, active-low reset
- PC_VALID  in  1  fetch request valid
- PC_READY  out  1  fetch request accepted when both high
- PC_PC  in  PC_W  fetch address; bits [1:0] ignored
- REDIRECT  in  1  flush: drop buffered instructions and the in-flight burst
- ARVALID  out  1; ARREADY  in  1; ARADDR  out  ADDR_W; ARLEN  out  8; ARBURST  out  2
- RVALID  in  1; RREADY  out  1; RDATA  in  DATA_W; RRESP  in  2; RLAST  in  1
- INST_VALID  out  1; INST_READY  in  1; INST_DATA  out  DATA_W; INST_PC  out  PC_W; INST_ERR  out  1

## Operation
- States: IDLE, ADDR, DATA, DRAIN. Reset enters IDLE with the FIFO empty.
- Reset values: all outputs 0, except ARLEN = BEATS-1 and ARBURST = `AXI_BURST_WRAP`, which are constant.
- PC_READY = (state==IDLE) && (fifo_empty || REDIRECT).
- Accept in IDLE:
  - Latch PC with bits [1:0] forced to 0.
  - off = PC[log2(BEATS)+1:2]; keep = BEATS - off.
  - Clear the beat counter k. Go to ADDR.
- ADDR:
  - ARVALID=1; ARADDR holds the latched address and stays stable until ARREADY.
  - On handshake, go to DATA, or to DRAIN if a redirect was flagged while in ADDR.
  - REDIRECT in ADDR sets a flush flag only; ARVALID is never retracted.
- DATA:
  - RREADY=1. Each beat increments k.
  - Beat k is written to the FIFO only if k < keep. Its PC = latched PC + 4k. Its error flag = (RRESP != OKAY).
  - Beats with k >= keep (wrapped lower words) are discarded.
  - RLAST ends the burst and returns to IDLE, regardless of k.
  - REDIRECT in DATA flushes the FIFO; go to DRAIN, or to IDLE if the same beat has RLAST.
- DRAIN: RREADY=1; all beats are discarded; RLAST goes to IDLE.
- REDIRECT in IDLE flushes the FIFO. A PC_VALID in the same cycle is accepted; the flush and the new request coexist.
- FIFO:
  - Depth BEATS. A burst starts only with the FIFO empty, so it never overflows; RREADY never depends on fullness.
  - Entries carry {data, pc, err}. The head drives the INST_* outputs.
  - Pop on INST_VALID && INST_READY. A flush wins over a same-cycle pop.
- INST_* outputs are stable while INST_VALID && !INST_READY.
- PC arithmetic is modulo 2^PC_W. Line offset arithmetic is modulo BEATS.

## Timing
- PC handshake at cycle t: ARVALID=1 at t+1.
- AR handshake at t1: DATA from t1+1; RREADY=1 at t1+1.
- Kept beat accepted at t2: INST_VALID=1 at t2+1. There is no bypass.
- Last instruction popped at c: PC_READY=1 at c+1.
- REDIRECT at r: INST_VALID=0 at r+1.
- Async reset mid-burst: outputs drop immediately. Beats still returned by the slave after reset are the system's responsibility.

## Structure
- Package leve_ifetch_pkg holds:
  - the state enum;
  - the RRESP OKAY constant;
  - the FIFO entry struct {data, pc, err}.
- AXI burst encodings come from the existing defs.vh macros.
- One sub-module, leve_ifetch_fifo: BEATS-deep synchronous FIFO with a flush input, an empty flag, and a registered head.

## Test plan
- PC=0x1000, ARREADY high, beats D0..D3 OKAY -> ARADDR=0x1000, ARLEN=3, ARBURST=WRAP; INST D0..D3 with PC 0x1000, 0x1004, 0x1008, 0x100C.
- PC=0x1008 -> slave returns words for 0x1008, 0x100C, 0x1000, 0x1004; only the first two are delivered (PC 0x1008, 0x100C); PC_READY=1 the cycle after the second pop.
- REDIRECT after beat 1 of 4 -> INST_VALID=0 next cycle; beats 2-3 accepted and discarded; PC_READY=0 until the cycle after RLAST.
- REDIRECT while ARREADY is held low 5 cycles -> ARVALID and ARADDR stable until the handshake; all 4 beats discarded; no INST_VALID.
- INST_READY low during the whole burst -> RREADY stays 1; 4 entries held; INST_DATA=D0 stable; on release D0..D3 pop on consecutive cycles.
- RRESP=SLVERR on beat 0 only -> INST_ERR=1 on the first instruction and 0 on the rest. RSTn low mid-DATA -> all outputs 0 immediately; IDLE with the FIFO empty after release.
